ccm_loader: RTL and testbench

CCM_LOADER -- requirements
Module: ccm_loader

---
 rtl/ccm_loader_pkg.sv | 16 +
 rtl/ccm_word_assembler.sv | 46 ++++
 rtl/ccm_loader.sv | 189 ++++++++++++++++++
 tb/tb_ccm_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_loader_pkg.sv
// Shared encodings for the CCM loader: stream command bytes and FSM state codes.
package ccm_loader_pkg;

   localparam logic [7:0] CMD_ICCM = 8'hA1;
   localparam logic [7:0] CMD_DCCM = 8'hA2;
   localparam logic [7:0] CMD_GO   = 8'hFF;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_HDR  = 3'd1;
   localparam state_t ST_DATA = 3'd2;
   localparam state_t ST_DONE = 3'd3;
   localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/ccm_word_assembler.sv
// Packs accepted bytes into little-endian 32-bit words; word_valid_o fires
// combinationally with the 4th byte so the caller can register the write.
module ccm_word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] buf_q, buf_d;

   always_comb begin
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (clr_i) begin
         cnt_d = 2'd0;
         buf_d = '0;
      end else if (byte_valid_i) begin
         cnt_d = cnt_q + 2'd1;
         case (cnt_q)
            2'd0:    buf_d[7:0]   = byte_i;
            2'd1:    buf_d[15:8]  = byte_i;
            2'd2:    buf_d[23:16] = byte_i;
            default: buf_d        = buf_q;
         endcase
      end
   end

   assign word_o       = {byte_i, buf_q};
   assign word_valid_o = byte_valid_i && !clr_i && (cnt_q == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         buf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         buf_q <= buf_d;
      end
   end

endmodule

// File: rtl/ccm_loader.sv
// Byte-stream loader for ICCM/DCCM; holds the core in reset until GO.
// core_rst_n is the core wrapper's only reset source, not the board reset.
//
// state | meaning
// IDLE  | waiting for a command byte
// HDR   | collecting 4 header bytes (addr lo/hi, count lo/hi)
// DATA  | assembling data words and writing them to the target
// DONE  | load complete, core released; sticky until rst_n
// ERR   | bad command seen, core held; sticky until rst_n
module ccm_loader
   import ccm_loader_pkg::*;
#(
   parameter int ICCM_AW = 14,  // 1..16
   parameter int DCCM_AW = 14   // 1..16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               iccm_we,
   output logic [ICCM_AW-1:0] iccm_addr,
   output logic [31:0]        iccm_wdata,
   output logic               dccm_we,
   output logic [DCCM_AW-1:0] dccm_addr,
   output logic [31:0]        dccm_wdata,
   output logic               core_rst_n,
   output logic               load_done,
   output logic               load_err
);

   localparam int ADDR_W = (ICCM_AW > DCCM_AW) ? ICCM_AW : DCCM_AW;

   state_t              state_q, state_d;
   logic                tgt_dccm_q, tgt_dccm_d;
   logic [1:0]          hdr_idx_q, hdr_idx_d;
   logic [7:0]          addr_lo_q, addr_lo_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [15:0]         remain_q, remain_d;
   logic [15:0]         count_full;
   logic                iccm_we_q, iccm_we_d;
   logic [ICCM_AW-1:0]  iccm_addr_q, iccm_addr_d;
   logic [31:0]         iccm_wdata_q, iccm_wdata_d;
   logic                dccm_we_q, dccm_we_d;
   logic [DCCM_AW-1:0]  dccm_addr_q, dccm_addr_d;
   logic [31:0]         dccm_wdata_q, dccm_wdata_d;
   logic                core_rst_n_q, core_rst_n_d;
   logic                load_done_q, load_done_d;
   logic                load_err_q, load_err_d;

   logic                accept;
   logic                asm_clr;
   logic                asm_valid;
   logic [31:0]         asm_word;
   logic                asm_word_valid;

   assign in_ready   = (state_q == ST_IDLE) || (state_q == ST_HDR) || (state_q == ST_DATA);
   assign accept     = in_valid && in_ready;
   assign asm_clr    = (state_q != ST_DATA);
   assign asm_valid  = accept && (state_q == ST_DATA);
   assign count_full = {in_data, remain_q[7:0]};

   ccm_word_assembler u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (asm_clr),
      .byte_valid_i (asm_valid),
      .byte_i       (in_data),
      .word_o       (asm_word),
      .word_valid_o (asm_word_valid)
   );

   always_comb begin
      state_d      = state_q;
      tgt_dccm_d   = tgt_dccm_q;
      hdr_idx_d    = hdr_idx_q;
      addr_lo_d    = addr_lo_q;
      waddr_d      = waddr_q;
      remain_d     = remain_q;
      iccm_we_d    = 1'b0;
      iccm_addr_d  = iccm_addr_q;
      iccm_wdata_d = iccm_wdata_q;
      dccm_we_d    = 1'b0;
      dccm_addr_d  = dccm_addr_q;
      dccm_wdata_d = dccm_wdata_q;
      core_rst_n_d = core_rst_n_q;
      load_done_d  = load_done_q;
      load_err_d   = load_err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (in_data == CMD_ICCM || in_data == CMD_DCCM) begin
                  state_d    = ST_HDR;
                  tgt_dccm_d = (in_data == CMD_DCCM);
                  hdr_idx_d  = 2'd0;
               end else if (in_data == CMD_GO) begin
                  state_d      = ST_DONE;
                  core_rst_n_d = 1'b1;
                  load_done_d  = 1'b1;
               end else begin
                  state_d    = ST_ERR;
                  load_err_d = 1'b1;
               end
            end
         end
         ST_HDR: begin
            if (accept) begin
               hdr_idx_d = hdr_idx_q + 2'd1;
               case (hdr_idx_q)
                  2'd0: addr_lo_d = in_data;
                  // header address bits above ADDR_W are dropped here
                  2'd1: waddr_d   = ADDR_W'({in_data, addr_lo_q});
                  2'd2: remain_d  = {8'h00, in_data};
                  default: begin
                     remain_d = count_full;
                     state_d  = (count_full == 16'd0) ? ST_IDLE : ST_DATA;
                  end
               endcase
            end
         end
         ST_DATA: begin
            if (asm_word_valid) begin
               if (tgt_dccm_q) begin
                  dccm_we_d    = 1'b1;
                  dccm_addr_d  = waddr_q[DCCM_AW-1:0];
                  dccm_wdata_d = asm_word;
               end else begin
                  iccm_we_d    = 1'b1;
                  iccm_addr_d  = waddr_q[ICCM_AW-1:0];
                  iccm_wdata_d = asm_word;
               end
               waddr_d  = waddr_q + 1'b1;
               remain_d = remain_q - 16'd1;
               if (remain_q == 16'd1) state_d = ST_IDLE;
            end
         end
         ST_DONE, ST_ERR: state_d = state_q;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tgt_dccm_q   <= 1'b0;
         hdr_idx_q    <= 2'd0;
         addr_lo_q    <= 8'h00;
         waddr_q      <= '0;
         remain_q     <= 16'd0;
         iccm_we_q    <= 1'b0;
         iccm_addr_q  <= '0;
         iccm_wdata_q <= '0;
         dccm_we_q    <= 1'b0;
         dccm_addr_q  <= '0;
         dccm_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         tgt_dccm_q   <= tgt_dccm_d;
         hdr_idx_q    <= hdr_idx_d;
         addr_lo_q    <= addr_lo_d;
         waddr_q      <= waddr_d;
         remain_q     <= remain_d;
         iccm_we_q    <= iccm_we_d;
         iccm_addr_q  <= iccm_addr_d;
         iccm_wdata_q <= iccm_wdata_d;
         dccm_we_q    <= dccm_we_d;
         dccm_addr_q  <= dccm_addr_d;
         dccm_wdata_q <= dccm_wdata_d;
         core_rst_n_q <= core_rst_n_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign iccm_we    = iccm_we_q;
   assign iccm_addr  = iccm_addr_q;
   assign iccm_wdata = iccm_wdata_q;
   assign dccm_we    = dccm_we_q;
   assign dccm_addr  = dccm_addr_q;
   assign dccm_wdata = dccm_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_ccm_loader.sv
// Scoreboard bench for ccm_loader: expected writes are queued before each frame
// and popped by a monitor whenever a write pulse appears.
module tb_ccm_loader;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        iccm_we;
   logic [13:0] iccm_addr;
   logic [31:0] iccm_wdata;
   logic        dccm_we;
   logic [13:0] dccm_addr;
   logic [31:0] dccm_wdata;
   logic        core_rst_n;
   logic        load_done;
   logic        load_err;

   typedef struct {
      bit          dccm;
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   int  total = 0;
   int  bad   = 0;

   ccm_loader #(.ICCM_AW(14), .DCCM_AW(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .iccm_we    (iccm_we),
      .iccm_addr  (iccm_addr),
      .iccm_wdata (iccm_wdata),
      .dccm_we    (dccm_we),
      .dccm_addr  (dccm_addr),
      .dccm_wdata (dccm_wdata),
      .core_rst_n (core_rst_n),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor
   always @(negedge clk) begin
      if (rst_n && (iccm_we || dccm_we)) begin
         wr_t exp_w;
         wr_t act_w;
         act_w.dccm = dccm_we;
         act_w.addr = dccm_we ? dccm_addr : iccm_addr;
         act_w.data = dccm_we ? dccm_wdata : iccm_wdata;
         total++;
         if (iccm_we && dccm_we) begin
            bad++;
            $display("FAIL we_exclusive: both iccm_we and dccm_we high, need one");
         end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got dccm=%0d addr=%h data=%h, need no write",
                     act_w.dccm, act_w.addr, act_w.data);
         end else begin
            exp_w = sb.pop_front();
            if (act_w.dccm !== exp_w.dccm || act_w.addr !== exp_w.addr || act_w.data !== exp_w.data) begin
               bad++;
               $display("FAIL write: got dccm=%0d addr=%h data=%h, need dccm=%0d addr=%h data=%h",
                        act_w.dccm, act_w.addr, act_w.data, exp_w.dccm, exp_w.addr, exp_w.data);
            end
         end
      end
   end

   task automatic push_wr(input bit d, input logic [13:0] a, input logic [31:0] w);
      wr_t e;
      e.dccm = d;
      e.addr = a;
      e.data = w;
      sb.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      total++;
      if ({core_rst_n, load_done, load_err, iccm_we, dccm_we} !== 5'b00000) begin
         bad++;
         $display("FAIL reset_flags: got %b, need 00000", {core_rst_n, load_done, load_err, iccm_we, dccm_we});
      end
      total++;
      if (iccm_addr !== 14'h0 || iccm_wdata !== 32'h0 || dccm_addr !== 14'h0 || dccm_wdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_bus: got %h %h %h %h, need zeros", iccm_addr, iccm_wdata, dccm_addr, dccm_wdata);
      end
      idle(2);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b, need 1", in_ready);
      end
   endtask

   task automatic test_iccm();
      logic [7:0] s[13] = '{8'hA1, 8'h00, 8'h00, 8'h02, 8'h00,
                            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      push_wr(1'b0, 14'h0000, 32'h44332211);
      push_wr(1'b0, 14'h0001, 32'h88776655);
      foreach (s[i]) send(s[i]);
      idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL iccm_drain: got %0d pending, need 0", sb.size());
      end
      total++;
      if (iccm_wdata !== 32'h88776655 || iccm_addr !== 14'h0001) begin
         bad++;
         $display("FAIL iccm_hold: got addr=%h data=%h, need 0001 88776655", iccm_addr, iccm_wdata);
      end
      total++;
      if (in_ready !== 1'b1 || core_rst_n !== 1'b0) begin
         bad++;
         $display("FAIL iccm_idle: got ready=%b core_rst_n=%b, need 1 0", in_ready, core_rst_n);
      end
   endtask

   task automatic test_dccm_wrap();
      // 0xFF bytes inside the frame are plain data
      logic [7:0] s[13] = '{8'hA2, 8'hFF, 8'h3F, 8'h02, 8'h00,
                            8'hFF, 8'hFF, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hFF, 8'h5A};
      push_wr(1'b1, 14'h3FFF, 32'h0100FFFF);
      push_wr(1'b1, 14'h0000, 32'h5AFFB2A1);
      foreach (s[i]) send(s[i]);
      idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL dccm_drain: got %0d pending, need 0", sb.size());
      end
      total++;
      if (load_done !== 1'b0 || load_err !== 1'b0) begin
         bad++;
         $display("FAIL dccm_flags: got done=%b err=%b, need 0 0", load_done, load_err);
      end
   endtask

   task automatic test_stall_and_reset();
      logic [7:0] h[5] = '{8'hA1, 8'h05, 8'h00, 8'h01, 8'h00};
      logic [7:0] d[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      logic [7:0] f[9] = '{8'hA2, 8'h20, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      do_reset();
      push_wr(1'b0, 14'h0005, 32'hEFBEADDE);
      foreach (h[i]) begin
         send(h[i]);
         idle(1);
      end
      foreach (d[i]) begin
         send(d[i]);
         idle(1);
      end
      idle(2);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL stall_drain: got %0d pending, need 0", sb.size());
      end
      // second frame cut by reset after two data bytes
      foreach (h[i]) send(h[i]);
      send(8'h11);
      send(8'h22);
      do_reset();
      #1;
      total++;
      if ({iccm_we, dccm_we, core_rst_n, load_done, load_err} !== 5'b00000 ||
          iccm_addr !== 14'h0 || iccm_wdata !== 32'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midframe_reset: got we=%b%b crn=%b addr=%h data=%h rdy=%b, need reset values",
                  iccm_we, dccm_we, core_rst_n, iccm_addr, iccm_wdata, in_ready);
      end
      push_wr(1'b1, 14'h0020, 32'h04030201);
      foreach (f[i]) send(f[i]);
      idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL post_reset_frame: got %0d pending, need 0", sb.size());
      end
   endtask

   task automatic test_go();
      logic [7:0] s[5] = '{8'hA1, 8'h10, 8'h00, 8'h00, 8'h00};
      do_reset();
      foreach (s[i]) send(s[i]);
      total++;
      if (core_rst_n !== 1'b0 || load_done !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL go_before: got crn=%b done=%b rdy=%b, need 0 0 1", core_rst_n, load_done, in_ready);
      end
      send(8'hFF);
      total++;
      if (core_rst_n !== 1'b1 || load_done !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL go_after: got crn=%b done=%b rdy=%b, need 1 1 0", core_rst_n, load_done, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h55;
      idle(4);
      in_valid = 1'b0;
      total++;
      if (core_rst_n !== 1'b1 || load_done !== 1'b1 || load_err !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL go_sticky: got crn=%b done=%b err=%b rdy=%b, need 1 1 0 0",
                  core_rst_n, load_done, load_err, in_ready);
      end
   endtask

   task automatic test_err();
      logic [7:0] f[9] = '{8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
      do_reset();
      send(8'h55);
      total++;
      if (load_err !== 1'b1 || in_ready !== 1'b0 || core_rst_n !== 1'b0) begin
         bad++;
         $display("FAIL err_entry: got err=%b rdy=%b crn=%b, need 1 0 0", load_err, in_ready, core_rst_n);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      idle(5);
      in_valid = 1'b0;
      total++;
      if (load_err !== 1'b1 || load_done !== 1'b0 || core_rst_n !== 1'b0) begin
         bad++;
         $display("FAIL err_sticky: got err=%b done=%b crn=%b, need 1 0 0", load_err, load_done, core_rst_n);
      end
      do_reset();
      #1;
      total++;
      if (load_err !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL err_exit: got err=%b rdy=%b, need 0 1", load_err, in_ready);
      end
      push_wr(1'b0, 14'h0000, 32'hBEBAFECA);
      foreach (f[i]) send(f[i]);
      idle(3);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL err_recover: got %0d pending, need 0", sb.size());
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_iccm();
      test_dccm_wrap();
      test_stall_and_reset();
      test_go();
      test_err();
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
